// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the single-clock FIFO: absorbs the 1-cycle read
// latency in a 2-entry skid buffer and emits a valid/ready stream with tlast.
module fifo_rd_stream #(
    parameter int DATA_W      = 8,
    parameter int PKT_MAX     = 512,
    parameter int IDLE_CYCLES = 16,
    parameter int CNT_W       = $clog2(PKT_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] fifo_rdata,
    input  logic              fifo_rvalid,
    input  logic              fifo_empty,
    output logic              fifo_ren,
    output logic [DATA_W-1:0] tdata,
    output logic              tvalid,
    input  logic              tready,
    output logic              tlast,
    output logic [CNT_W-1:0]  pkt_words
);

    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(PKT_MAX - 1);
    localparam logic [IDLE_W-1:0] IDLE_END = IDLE_W'(IDLE_CYCLES - 1);

    logic [DATA_W-1:0] r_buf [2];
    logic [1:0]        r_cnt;
    logic              r_inflight;
    logic              r_flush;
    logic [IDLE_W-1:0] r_idle;
    logic [CNT_W-1:0]  r_pkt;

    logic       w_pop;
    logic       w_app;
    logic       w_idle;
    logic       w_wr_idx;
    logic [1:0] w_occ;

    assign w_occ  = r_cnt + {1'b0, r_inflight};
    assign w_app  = fifo_rvalid && r_inflight;

    // A lone word with no known successor waits so tlast is settled first
    assign tvalid = (r_cnt != 2'd0) &&
                    (r_cnt[1] || r_inflight || !fifo_empty || r_flush);
    assign w_pop  = tvalid && tready;

    assign fifo_ren  = !rst && !fifo_empty && ((w_occ < 2'd2) || w_pop);
    assign tdata     = r_buf[0];
    assign tlast     = tvalid && ((r_pkt == LAST_IDX) || r_flush);
    assign pkt_words = r_pkt;

    assign w_idle = (r_cnt == 2'd1) && !r_inflight && fifo_empty && !tvalid;

    // Appends only happen with at most one word held, so the slot is 0 or 1
    assign w_wr_idx = r_cnt[0] && !w_pop;

    always_ff @(posedge clk) begin
        if (w_pop)
            r_buf[0] <= r_buf[1];
        if (w_app)
            r_buf[w_wr_idx] <= fifo_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 2'd0;
            r_inflight <= 1'b0;
            r_flush    <= 1'b0;
            r_idle     <= '0;
            r_pkt      <= '0;
        end else begin
            r_cnt <= r_cnt + {1'b0, w_app} - {1'b0, w_pop};
            if (fifo_ren)
                r_inflight <= 1'b1;
            else if (w_app)
                r_inflight <= 1'b0;
            if (w_idle) begin
                r_idle <= r_idle + IDLE_W'(1);
                if (r_idle == IDLE_END)
                    r_flush <= 1'b1;
            end else begin
                r_idle <= '0;
                if (w_pop && r_flush)
                    r_flush <= 1'b0;
            end
            if (w_pop)
                r_pkt <= tlast ? '0 : r_pkt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(fifo_rvalid && !r_inflight));
    end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side adapter that sits directly downstream of the single-clock FIFO.
- Drives the FIFO's `ren`, absorbs its 1-cycle `rvalid`/`rdata` latency in a 2-entry skid buffer, and presents a valid/ready byte stream with `tlast` framing.
- Packets close after PKT_MAX words, or after the FIFO has stayed empty for IDLE_CYCLES with one word pending.
- Feeds the packet-oriented transmit path, e.g. host-bound FT245 frames.

Parameters:
- DATA_W, 8, width of FIFO words and stream data.
- PKT_MAX, 512, maximum words per packet (>=1); `tlast` is forced on word PKT_MAX.
- IDLE_CYCLES, 16, idle cycles (>=1) before a lone pending word is flushed with `tlast`=1.
- CNT_W, $clog2(PKT_MAX+1), width of the packet word counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- fifo_rdata  input  DATA_W  FIFO read data; valid when `fifo_rvalid`=1.
- fifo_rvalid  input  1  FIFO read data valid; 1 cycle after an accepted `ren`.
- fifo_empty  input  1  FIFO empty flag.
- fifo_ren  output  1  FIFO read request.
- tdata  output  DATA_W  stream data.
- tvalid  output  1  stream valid.
- tready  input  1  stream ready.
- tlast  output  1  last word of packet.
- pkt_words  output  CNT_W  words accepted so far in the current packet.

Behaviour:
- Reset values: `tvalid`=0, `tlast`=0, `pkt_words`=0, `fifo_ren`=0 (gated by `rst`), buffer count=0, inflight=0, idle counter=0, flush flag=0.
- Reset mid-operation discards buffered and inflight words. The upstream FIFO shares `rst`, so no stale `rvalid` is expected.
- State variables:
  - `buf_cnt` (0..2), in-order 2-entry buffer; head = oldest.
  - `inflight` (0..1), a read issued whose `rvalid` is not yet seen.
  - Invariant: `buf_cnt` + `inflight` <= 2.
- pop = `tvalid` && `tready`.
- `fifo_ren` = !`rst` && !`fifo_empty` && ((`buf_cnt`+`inflight`) < 2 || pop).
  - Read issued on cycle N sets `inflight`; `fifo_rvalid` on N+1 appends `fifo_rdata` to the buffer tail.
  - Append and pop in the same cycle are allowed; count unchanged.
  - Sustained throughput is 1 word/cycle with `tready` held high.
- Presentation rule: `tvalid` = (`buf_cnt` >= 1) && (`buf_cnt`==2 || `inflight` || !`fifo_empty` || flush).
  - A lone word with no known successor is held back, so `tlast` is decided before `tvalid` rises.
- `tdata` = head entry.
  - `tdata` and `tlast` stay stable while `tvalid` && !`tready`.
  - `tvalid` never drops without a pop.
- `tlast` = `tvalid` && (`pkt_words` == PKT_MAX-1 || flush).
- Idle counter:
  - Increments while `buf_cnt`==1 && !`inflight` && `fifo_empty` && !`tvalid`; clears otherwise.
  - On reaching IDLE_CYCLES-1 it sets flush; `tvalid` rises next cycle with `tlast`=1.
  - flush stays set until that word pops, even if new data arrives meanwhile.
- `pkt_words`:
  - +1 on each pop without `tlast`.
  - Cleared to 0 on a pop with `tlast`.
  - Never exceeds PKT_MAX-1.
- Simultaneous count limit and flush: one `tlast`, counter cleared once.
- Never asserts `fifo_ren` when `fifo_empty`=1.
- Ignores `fifo_rvalid` when `inflight`=0; this is an assertion error in sim.

Test Plan:
- Preload FIFO with 0x01..0x08, `tready`=1: `fifo_ren` high 8 consecutive cycles. Words 0x01..0x07 emitted one per cycle, `tlast`=0. 0x08 held, then emitted with `tlast`=1 exactly IDLE_CYCLES+1 cycles after its `rvalid`. `pkt_words` returns to 0.
- PKT_MAX=4, stream 10 words continuously: `tlast`=1 on the 4th and 8th words. Words 9-10 close via idle flush. No bubbles between words 1-8.
- `tready` toggling 1,0,0,1 during a 6-word burst: `tdata`/`tlast` unchanged across stalled cycles. Buffer never exceeds 2 and `fifo_ren` deasserts while full. All 6 words delivered in order with no loss or duplication.
- Single word 0xA5 written; a second word 0x5A written 5 cycles later (IDLE_CYCLES=16): 0xA5 emitted with `tlast`=0 once 0x5A is in flight. 0x5A then flushed with `tlast`=1 after 16 idle cycles.
- Flush raised with `tready`=0, new word 0x33 arrives next cycle: held word keeps `tlast`=1 until accepted. 0x33 starts a new packet with `pkt_words`=0.
- Assert `rst` for 1 cycle with 2 words buffered and 1 inflight: next cycle `tvalid`=0, `fifo_ren`=0, `pkt_words`=0. A following burst of 3 words delivers exactly those 3.
